// File: rtl/router_pkg.sv
// router_pkg: shared header field positions, FSM encoding and default stall timeout
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = ADDR_W;
  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
  localparam int TIMEOUT_DEF = 30;
  typedef enum logic [1:0] {S_HDR, S_BODY, S_PAR} state_e;
endpackage

// File: rtl/router_pkt_reader_if.sv
// router_pkt_reader_if: FIFO read side + destination packet port + statistics of one router output
//  master (reader): fifo_empty/fifo_data/dest_ready in; fifo_rd_en, soft_reset, pkt_*, parity_err, counters out
//  slave  (env)   : the mirror image
interface router_pkt_reader_if #(
  parameter int DW = 8,
  parameter int CNTW = 16
);
  logic fifo_empty;
  logic [DW-1:0] fifo_data;
  logic fifo_rd_en;
  logic soft_reset;
  logic [DW-1:0] pkt_data;
  logic pkt_valid;
  logic pkt_sop;
  logic pkt_eop;
  logic dest_ready;
  logic parity_err;
  logic [CNTW-1:0] pkt_count;
  logic [CNTW-1:0] drop_count;
  modport master (
    input fifo_empty, fifo_data, dest_ready,
    output fifo_rd_en, soft_reset, pkt_data, pkt_valid, pkt_sop, pkt_eop, parity_err, pkt_count, drop_count
  );
  modport slave (
    output fifo_empty, fifo_data, dest_ready,
    input fifo_rd_en, soft_reset, pkt_data, pkt_valid, pkt_sop, pkt_eop, parity_err, pkt_count, drop_count
  );
endinterface

// File: rtl/router_skid2.sv
// router_skid2: 2-entry skid buffer between FIFO read data and the destination port
//  push/din: write one byte; pop: drop head; flush: empty the buffer (wins over push/pop)
//  dout: head byte; occ: number of bytes held (0..2)
module router_skid2 #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] occ_q, occ_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    occ_d = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      occ_q <= occ_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign occ = occ_q;
endmodule

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains one router output FIFO, re-frames packets (sop/eop) and checks parity
//  clock/resetn: rising-edge clock, async active-low reset
//  io (master):  FIFO read (fifo_empty, fifo_data, fifo_rd_en, soft_reset),
//                destination port (pkt_data/valid/sop/eop, dest_ready), parity_err, pkt_count, drop_count
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int DW = 8,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNTW = 16
) (
  input logic clock,
  input logic resetn,
  router_pkt_reader_if.master io
);
  localparam int SW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [DW-1:0] par_q, par_d, head;
  logic perr_q, perr_d, soft_reset_q, soft_reset_d, inflight_q, inflight_d;
  logic [CNTW-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [1:0] occ;
  logic valid, accept, stall, timeout, rd_en;
  router_skid2 #(.DW(DW)) u_skid (
    .clock(clock), .resetn(resetn), .push(inflight_q), .pop(accept), .flush(timeout),
    .din(io.fifo_data), .dout(head), .occ(occ)
  );
  // Read credit counts occupancy net of this cycle's pop, so a steady 1 byte/cycle stream
  // keeps issuing while the skid never overflows when the in-flight byte lands.
  // A read issued in the timeout cycle is dropped along with the flushed skid.
  always_comb begin
    valid = occ != 2'd0;
    accept = valid & io.dest_ready;
    stall = valid & ~io.dest_ready;
    timeout = stall & (stall_q == SW'(TIMEOUT - 1));
    rd_en = resetn & ~io.fifo_empty & ~soft_reset_q & ((occ - {1'b0, accept} + {1'b0, inflight_q}) < 2'd2);
    inflight_d = rd_en & ~timeout;
    soft_reset_d = timeout;
    stall_d = stall ? stall_q + SW'(1) : '0;
    state_d = state_q;
    rem_d = rem_q;
    par_d = par_q;
    perr_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (timeout) begin
      state_d = S_HDR;
      drop_cnt_d = drop_cnt_q + CNTW'(1);
    end else if (accept) begin
      case (state_q)
        S_HDR: begin
          rem_d = head[LEN_MSB:LEN_LSB];
          par_d = head;
          state_d = (head[LEN_MSB:LEN_LSB] != '0) ? S_BODY : S_PAR;
        end
        S_BODY: begin
          rem_d = rem_q - LEN_W'(1);
          par_d = par_q ^ head;
          state_d = (rem_q == LEN_W'(1)) ? S_PAR : S_BODY;
        end
        S_PAR: begin
          perr_d = head != par_q;
          pkt_cnt_d = pkt_cnt_q + CNTW'(1);
          state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_HDR;
      rem_q <= '0;
      par_q <= '0;
      perr_q <= 1'b0;
      soft_reset_q <= 1'b0;
      inflight_q <= 1'b0;
      pkt_cnt_q <= '0;
      drop_cnt_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      par_q <= par_d;
      perr_q <= perr_d;
      soft_reset_q <= soft_reset_d;
      inflight_q <= inflight_d;
      pkt_cnt_q <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      stall_q <= stall_d;
    end
  end
  assign io.fifo_rd_en = rd_en;
  assign io.soft_reset = soft_reset_q;
  assign io.pkt_data = head;
  assign io.pkt_valid = valid;
  assign io.pkt_sop = valid & (state_q == S_HDR);
  assign io.pkt_eop = valid & (state_q == S_PAR);
  assign io.parity_err = perr_q;
  assign io.pkt_count = pkt_cnt_q;
  assign io.drop_count = drop_cnt_q;
endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: scoreboard bench with FIFO model, packet-level reference and stall model
module tb_router_pkt_reader;
  localparam int TIMEOUT = 30;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [7:0] data; logic sop; logic eop; logic bad;} beat_t;
  logic clock, resetn;
  router_pkt_reader_if #(.DW(8), .CNTW(16)) io();
  router_pkt_reader #(.DW(8), .TIMEOUT(TIMEOUT), .CNTW(16)) dut (.clock(clock), .resetn(resetn), .io(io));
  logic [7:0] fq[$];
  beat_t exp_q[$];
  int acc_cyc[$];
  int cmp_n = 0, err_n = 0, cyc = 0, run = 0, acc_n = 0, pkt_m = 0, drop_m = 0;
  logic perr_next = 0, prev_sr = 0, done = 0;
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    cmp_n++;
    if (act !== req) begin
      err_n++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", n, act, req, cyc);
    end
  endtask
  function automatic bq_t make_pkt(input int l, input bit bad);
    bq_t b;
    logic [7:0] p;
    b.push_back({6'(l), 2'($urandom_range(0, 3))});
    for (int i = 0; i < l; i++) b.push_back(8'($urandom));
    p = 0;
    foreach (b[i]) p ^= b[i];
    b.push_back(bad ? p ^ 8'($urandom_range(1, 255)) : p);
    return b;
  endfunction
  task automatic push_pkt(input bq_t b);
    logic [7:0] x = 0;
    for (int i = 0; i < b.size(); i++) begin
      beat_t e;
      fq.push_back(b[i]);
      e.data = b[i];
      e.sop = i == 0;
      e.eop = i == b.size() - 1;
      e.bad = (i == b.size() - 1) && (b[i] != x);
      exp_q.push_back(e);
      x ^= b[i];
    end
  endtask
  task automatic drain(input string n, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < budget) begin
      @(posedge clock);
      k++;
    end
    if (k >= budget) chk({n, "_drain_timeout"}, 32'(exp_q.size()), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask
  always @(posedge clock) cyc++;
  always @(posedge clock)
    if (resetn) begin
      if (io.soft_reset) begin
        fq.delete();
        io.fifo_data <= 8'($urandom);
      end else if (io.fifo_rd_en && fq.size() > 0) io.fifo_data <= fq.pop_front();
      else io.fifo_data <= 8'($urandom);
    end
  always @(negedge clock) io.fifo_empty = fq.size() == 0;
  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      run = 0;
      perr_next = 0;
      prev_sr = 0;
      pkt_m = 0;
      drop_m = 0;
    end else begin
      logic exp_sr;
      exp_sr = run == TIMEOUT;
      chk("soft_reset", 32'(io.soft_reset), 32'(exp_sr));
      if (prev_sr) chk("valid_after_flush", 32'(io.pkt_valid), 0);
      if (exp_sr) begin
        drop_m++;
        exp_q.delete();
      end
      prev_sr = exp_sr;
      chk("parity_err", 32'(io.parity_err), 32'(perr_next));
      perr_next = 0;
      run = (io.pkt_valid && !io.dest_ready) ? run + 1 : 0;
      if (io.pkt_valid && io.dest_ready) begin
        acc_n++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(io.pkt_data), 32'hFFFF_FFFF);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("pkt_data", 32'(io.pkt_data), 32'(e.data));
          chk("pkt_sop", 32'(io.pkt_sop), 32'(e.sop));
          chk("pkt_eop", 32'(io.pkt_eop), 32'(e.eop));
          if (e.eop) begin
            perr_next = e.bad;
            pkt_m++;
          end
        end
      end
    end
  end
  task automatic chk_idle_outputs(input string n);
    chk({n, "_valid"}, 32'(io.pkt_valid), 0);
    chk({n, "_sop_eop"}, 32'({io.pkt_sop, io.pkt_eop}), 0);
    chk({n, "_rd_en"}, 32'(io.fifo_rd_en), 0);
    chk({n, "_soft_reset"}, 32'(io.soft_reset), 0);
    chk({n, "_parity_err"}, 32'(io.parity_err), 0);
    chk({n, "_pkt_data"}, 32'(io.pkt_data), 0);
    chk({n, "_pkt_count"}, 32'(io.pkt_count), 0);
    chk({n, "_drop_count"}, 32'(io.drop_count), 0);
  endtask
  task automatic wait_valid(input string n);
    int k = 0;
    @(negedge clock);
    while (!io.pkt_valid && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (k >= 50) chk({n, "_valid_timeout"}, 32'(io.pkt_valid), 1);
  endtask
  initial begin
    resetn = 0;
    io.dest_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    resetn = 1;
    // 1: nominal packet, back-to-back delivery
    io.dest_ready = 1;
    acc_cyc.delete();
    push_pkt('{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D});
    drain("t1", 100);
    chk("t1_beats", 32'(acc_cyc.size()), 5);
    if (acc_cyc.size() == 5) chk("t1_back_to_back", 32'(acc_cyc[4] - acc_cyc[0]), 4);
    chk("t1_pkt_count", 32'(io.pkt_count), 1);
    // 2: zero-length packet
    push_pkt('{8'h02, 8'h02});
    drain("t2", 100);
    chk("t2_pkt_count", 32'(io.pkt_count), 2);
    // 3: corrupted parity byte
    push_pkt('{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E});
    drain("t3", 100);
    chk("t3_pkt_count", 32'(io.pkt_count), 3);
    // 4: 29 stalled cycles survive
    io.dest_ready = 0;
    push_pkt(make_pkt(4, 0));
    wait_valid("t4");
    repeat (29) @(posedge clock);
    #1 io.dest_ready = 1;
    drain("t4", 200);
    chk("t4_drop_count", 32'(io.drop_count), 0);
    chk("t4_pkt_count", 32'(io.pkt_count), 4);
    // 5: 30+ stalled cycles flush, then a fresh packet is framed
    io.dest_ready = 0;
    push_pkt(make_pkt(5, 0));
    wait_valid("t5");
    repeat (40) @(posedge clock);
    #1;
    chk("t5_drop_count", 32'(io.drop_count), 1);
    chk("t5_flushed_valid", 32'(io.pkt_valid), 0);
    io.dest_ready = 1;
    push_pkt(make_pkt(3, 0));
    drain("t5", 200);
    chk("t5_pkt_count", 32'(io.pkt_count), 5);
    // 6: async reset mid-payload
    begin
      int base = acc_n, k = 0;
      push_pkt(make_pkt(20, 0));
      while (acc_n < base + 3 && k < 100) begin
        @(posedge clock);
        k++;
      end
      if (k >= 100) chk("t6_start_timeout", 32'(acc_n - base), 3);
    end
    @(posedge clock);
    #3 resetn = 0;
    fq.delete();
    #1 chk_idle_outputs("async_reset");
    repeat (2) @(posedge clock);
    #1 resetn = 1;
    push_pkt('{8'h02, 8'h02});
    drain("t6", 100);
    chk("t6_pkt_count", 32'(io.pkt_count), 1);
    // random traffic with random backpressure
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          push_pkt(make_pkt($urandom_range(0, 12), $urandom_range(0, 4) == 0));
          repeat ($urandom_range(0, 3)) @(posedge clock);
          #1;
        end
        drain("rand", 5000);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 io.dest_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    chk("final_pkt_count", 32'(io.pkt_count), 32'(pkt_m));
    chk("final_drop_count", 32'(io.drop_count), 32'(drop_m));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
